// File: rtl/s4ga_pkg.sv
// Shared sizing helpers and default configuration for the s4ga_sync LUT fabric.
package s4ga_pkg;

    // Default fabric configuration
    localparam int DEF_N    = 89;
    localparam int DEF_K    = 5;
    localparam int DEF_SI_W = 4;
    localparam int DEF_X_W  = 4;
    localparam int DEF_O_W  = 8;

    // Number of SI_W-bit beats needed to carry a w-bit field (ceiling division)
    function automatic int seg_count(input int w, input int si_w);
        return (w + si_w - 1) / si_w;
    endfunction

    // Width of a counter that must hold values 0..states-1 (never narrower than 1 bit)
    function automatic int cnt_width(input int states);
        return (states <= 2) ? 1 : $clog2(states);
    endfunction

    // Frame field sizes derived from the fabric parameters
    function automatic int idx_width(input int n, input int x_w);
        return $clog2(n + x_w);
    endfunction

    function automatic int mask_width(input int k);
        return 2 ** k;
    endfunction

    // Derived sizes of the default configuration
    localparam int DEF_IDX_W     = idx_width(DEF_N, DEF_X_W);
    localparam int DEF_MASK_W    = mask_width(DEF_K);
    localparam int DEF_IDX_SEGS  = seg_count(DEF_IDX_W, DEF_SI_W);
    localparam int DEF_MASK_SEGS = seg_count(DEF_MASK_W, DEF_SI_W);

    // Which part of a frame is being received
    typedef enum logic {
        PH_INDEX = 1'b0,
        PH_MASK  = 1'b1
    } phase_t;

endpackage

// File: rtl/s4ga_frame_ctl.sv
// Frame sequencer: tracks LUT number n, field number k and segment seg of the
// incoming configuration stream and flags field, frame and epoch boundaries.
module s4ga_frame_ctl
    import s4ga_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int K         = DEF_K,
    parameter int IDX_SEGS  = DEF_IDX_SEGS,
    parameter int MASK_SEGS = DEF_MASK_SEGS,
    parameter int N_W       = cnt_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           si_valid,
    input  logic           sync_clr,
    output logic [N_W-1:0] n,
    output logic           beat,
    output logic           idx_done,
    output logic           mask_done,
    output logic           epoch_end
);

    localparam int K_W   = cnt_width(K + 1);
    localparam int SEG_W = cnt_width((IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS);

    logic [N_W-1:0]   n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    phase_t           phase;
    logic             seg_last;

    assign n = n_q;

    // Counter registers; they move only through the next-state logic below
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q   <= '0;
            k_q   <= '0;
            seg_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            n_q   <= n_d;
            k_q   <= k_d;
            seg_q <= seg_d;
        end
    end

    // Strobes and next counter values; a beat coinciding with sync_clr is dropped
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        n_d   = n_q;
        k_d   = k_q;
        seg_d = seg_q;

        phase     = (k_q == K_W'(K)) ? PH_MASK : PH_INDEX;
        seg_last  = (phase == PH_MASK) ? (seg_q == SEG_W'(MASK_SEGS - 1))
                                       : (seg_q == SEG_W'(IDX_SEGS - 1));
        beat      = si_valid && !sync_clr;
        idx_done  = beat && (phase == PH_INDEX) && seg_last;
        mask_done = beat && (phase == PH_MASK) && seg_last;
        epoch_end = mask_done && (n_q == N_W'(N - 1));

        if (sync_clr) begin
            n_d   = '0;
            k_d   = '0;
            seg_d = '0;
        end else if (beat) begin
            if (!seg_last) begin
                seg_d = seg_q + SEG_W'(1);
            end else begin
                seg_d = '0;
                if (phase == PH_INDEX) begin
                    k_d = k_q + K_W'(1);
                end else begin
                    k_d = '0;
                    n_d = epoch_end ? '0 : n_q + N_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/s4ga_sync.sv
// Streaming-configuration LUT fabric with two-phase state: each completed frame
// evaluates one LUT into next[], and the whole epoch is committed to cur[] at once.
module s4ga_sync
    import s4ga_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int K    = DEF_K,
    parameter int SI_W = DEF_SI_W,
    parameter int X_W  = DEF_X_W,
    parameter int O_W  = DEF_O_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            si_valid,
    input  logic [SI_W-1:0] si,
    input  logic            sync_clr,
    input  logic [X_W-1:0]  xin,
    output logic [O_W-1:0]  out,
    output logic            epoch_done
);

    localparam int IDX_W     = idx_width(N, X_W);
    localparam int MASK_W    = mask_width(K);
    localparam int IDX_SEGS  = seg_count(IDX_W, SI_W);
    localparam int MASK_SEGS = seg_count(MASK_W, SI_W);
    localparam int MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SH_W      = MAX_SEGS * SI_W;
    localparam int N_W       = cnt_width(N);

    logic [N_W-1:0]     n;
    logic               beat, idx_done, mask_done, epoch_end;
    logic [N-1:0]       cur, nxt, nxt_upd;
    logic [X_W-1:0]     xreg;
    logic [SH_W-1:0]    sh, field;
    logic [IDX_W-1:0]   idx;
    logic [MASK_W-1:0]  mask;
    logic [N+X_W-1:0]   pool;
    logic [K-1:0]       ins, ins_next;
    logic [K:0]         ins_ext;
    logic               sel_bit, lut_bit;

    s4ga_frame_ctl #(
        .N         (N),
        .K         (K),
        .IDX_SEGS  (IDX_SEGS),
        .MASK_SEGS (MASK_SEGS),
        .N_W       (N_W)
    ) u_frame_ctl (
        .clk       (clk),
        .rst       (rst),
        .si_valid  (si_valid),
        .sync_clr  (sync_clr),
        .n         (n),
        .beat      (beat),
        .idx_done  (idx_done),
        .mask_done (mask_done),
        .epoch_end (epoch_end)
    );

    // Field assembly (MSB segment first), index decode and LUT evaluation
    always_comb begin
        field    = SH_W'({sh, si});
        idx      = field[IDX_W-1:0];
        mask     = field[MASK_W-1:0];
        pool     = {xreg, cur};
        sel_bit  = 1'b0;
        if (int'(idx) < N + X_W) begin
            sel_bit = pool[idx];
        end
        ins_ext  = {ins, sel_bit};
        ins_next = ins_ext[K-1:0];
        lut_bit  = mask[ins];
        nxt_upd  = nxt;
        nxt_upd[n] = lut_bit;
    end

    // Shift register and LUT input vector, both realigned by sync_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            ins <= '0;
        end else if (sync_clr) begin
            sh  <= '0;
            ins <= '0;
        end else if (beat) begin
            sh <= (idx_done || mask_done) ? '0 : field;
            if (idx_done) begin
                ins <= ins_next;
            end
        end
    end

    // Two-phase LUT state, external input sample and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: cur/nxt are plain flop vectors, not RAM, so they are cleared by reset like any other state.
            cur        <= '0;
            nxt        <= '0;
            xreg       <= '0;
            out        <= '0;
            epoch_done <= 1'b0;
        end else begin
            epoch_done <= epoch_end;
            if (sync_clr) begin
                nxt <= cur;
            end else if (mask_done) begin
                nxt <= nxt_upd;
                if (epoch_end) begin
                    cur  <= nxt_upd;
                    xreg <= xin;
                    out  <= nxt_upd[O_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_s4ga_sync.sv
// Scoreboard bench for s4ga_sync: the driver pushes the expected out value and
// commit cycle of every full epoch; a monitor checks each epoch_done and that
// out holds between commits.
module tb_s4ga_sync;

    localparam int N    = 7;
    localparam int K    = 2;
    localparam int SI_W = 4;
    localparam int X_W  = 2;
    localparam int O_W  = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            si_valid = 1'b0;
    logic [SI_W-1:0] si = '0;
    logic            sync_clr = 1'b0;
    logic [X_W-1:0]  xin = '0;
    logic [O_W-1:0]  out;
    logic            epoch_done;

    s4ga_sync #(
        .N    (N),
        .K    (K),
        .SI_W (SI_W),
        .X_W  (X_W),
        .O_W  (O_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .si_valid   (si_valid),
        .si         (si),
        .sync_clr   (sync_clr),
        .xin        (xin),
        .out        (out),
        .epoch_done (epoch_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [O_W-1:0] val;
        int             cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: LUT state per epoch, frames as (index0, index1, mask)
    bit cur_m[N];
    bit x_m[X_W];
    int f0[N];
    int f1[N];
    int fm[N];

    function automatic bit src(input int idx);
        if (idx < N) return cur_m[idx];
        if (idx < N + X_W) return x_m[idx - N];
        return 1'b0;
    endfunction

    // Monitor: compare on every epoch_done, otherwise out must hold
    logic [O_W-1:0] exp_out = '0;
    exp_t           got;
    always @(negedge clk) begin
        if (rst) begin
            exp_out = '0;
        end else if (epoch_done) begin
            if (sb.size() == 0) begin
                check("spurious_epoch_done", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("epoch_out", 32'(out), 32'(got.val));
                check("epoch_cycle", cyc, got.cyc);
                exp_out = got.val;
            end
        end else begin
            check("out_hold", 32'(out), 32'(exp_out));
        end
    end

    task automatic beat(input logic [SI_W-1:0] d, input int stall);
        while ($urandom_range(99) < stall) begin
            si_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        si_valid = 1'b1;
        si       = d;
        @(posedge clk);
        #1;
        si_valid = 1'b0;
    endtask

    task automatic run_epoch(input int stall);
        bit             nc[N];
        int             sel;
        exp_t           e;
        for (int i = 0; i < N; i++) begin
            sel   = 2 * int'(src(f0[i])) + int'(src(f1[i]));
            nc[i] = fm[i][sel];
        end
        for (int i = 0; i < N; i++) begin
            beat(4'(f0[i]), stall);
            beat(4'(f1[i]), stall);
            beat(4'(fm[i]), stall);
        end
        for (int i = 0; i < N; i++) cur_m[i] = nc[i];
        for (int j = 0; j < X_W; j++) x_m[j] = xin[j];
        for (int i = 0; i < O_W; i++) e.val[i] = nc[i];
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic partial(input int nbeats);
        int b = 0;
        for (int i = 0; i < N && b < nbeats; i++) begin
            if (b < nbeats) begin beat(4'(f0[i]), 0); b++; end
            if (b < nbeats) begin beat(4'(f1[i]), 0); b++; end
            if (b < nbeats) begin beat(4'(fm[i]), 0); b++; end
        end
    endtask

    task automatic set_frames(input int kind);
        for (int i = 0; i < N; i++) begin
            f0[i] = i; f1[i] = i; fm[i] = 8;
            if (kind == 0) fm[i] = 1;
        end
        if (kind == 1) begin
            f0[0] = 0; f1[0] = 0; fm[0] = 1;
            f0[1] = 0; f1[1] = 0; fm[1] = 8;
        end
        if (kind == 2) begin
            f0[0] = 7;  f1[0] = 7;  fm[0] = 8;
            f0[2] = 12; f1[2] = 12; fm[2] = 1;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_out", 32'(out), 32'd0);
        check("reset_epoch_done", 32'(epoch_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Inverter epochs, continuous valid: 7F, 00, 7F
        set_frames(0);
        run_epoch(0);
        run_epoch(0);
        run_epoch(0);

        // Asynchronous reset in the middle of an epoch
        partial(10);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_epoch_done", 32'(epoch_done), 32'd0);
        for (int i = 0; i < N; i++) cur_m[i] = 1'b0;
        for (int j = 0; j < X_W; j++) x_m[j] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_epoch(0);
        run_epoch(0);

        // Synchronous semantics: LUT1 lags LUT0 by one epoch
        set_frames(1);
        run_epoch(0);
        run_epoch(0);

        // External and out-of-range indices
        xin = 2'b01;
        set_frames(2);
        run_epoch(0);
        run_epoch(0);

        // Inverter epochs with random stalls
        set_frames(0);
        run_epoch(50);
        run_epoch(50);

        // sync_clr mid-epoch with a coincident beat that must be discarded
        partial(10);
        sync_clr = 1'b1;
        si_valid = 1'b1;
        si       = 4'hF;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        si_valid = 1'b0;
        run_epoch(0);

        // Random frames, inputs and stalls
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < N; i++) begin
                f0[i] = int'($urandom_range(15));
                f1[i] = int'($urandom_range(15));
                fm[i] = int'($urandom_range(15));
            end
            xin = X_W'($urandom_range(3));
            run_epoch(int'($urandom_range(60)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
